// File: rtl/bt_chan_pkg.sv
// Shared types and constants for the air-channel model.
// Latency: n/a (package only).
// Backpressure: n/a.
package bt_chan_pkg;

  localparam int SYM_W  = 3;
  localparam int FK_W   = 7;
  localparam int LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on state bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } chan_state_t;

  // One delay-line slot: what the transmitter put on air at one tick
  typedef struct packed {
    logic             vld;
    logic [FK_W-1:0]  fk;
    logic [SYM_W-1:0] sym;
  } chan_entry_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bt_chan_lfsr.sv
// 16-bit Fibonacci LFSR stepped by an enable, reset to SEED.
// Latency: new state visible the cycle after step.
// Backpressure: none; step is a free-running strobe.
// Ports: clk_6M, rstz (async active-low), step, lfsr (current state).
module bt_chan_lfsr
  import bt_chan_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              step,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/bt_air_channel.sv
// One-direction air link: TX symbols delayed, hop/enable gated, bit-error injected.
// Latency: effective delay d ticks of p_1us, output registered one clk after the read tick.
// Backpressure: none; one symbol accepted and one slot read every p_1us tick.
// Ports: clk_6M/rstz; p_1us strobe; tx_symbol/tx_fk/tx_en from TX; rx_fk/rx_en from RX;
//        regi_delay_us, regi_ber_thresh, regi_stat_clr_p config; rx_symbol/rx_valid/chan_busy out.
// Build option: define BT_AIR_CHAN_STATS_EN to add stat_sym_cnt/stat_err_cnt/stat_miss_cnt.
module bt_air_channel
  import bt_chan_pkg::*;
#(
  parameter int          DELAY_MAX = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             p_1us,
  input  logic [SYM_W-1:0] tx_symbol,
  input  logic [FK_W-1:0]  tx_fk,
  input  logic             tx_en,
  input  logic [FK_W-1:0]  rx_fk,
  input  logic             rx_en,
  input  logic [3:0]       regi_delay_us,
  input  logic [9:0]       regi_ber_thresh,
  input  logic             regi_stat_clr_p,
  output logic [SYM_W-1:0] rx_symbol,
  output logic             rx_valid,
  output logic             chan_busy
`ifdef BT_AIR_CHAN_STATS_EN
  ,
  output logic [15:0]      stat_sym_cnt,
  output logic [15:0]      stat_err_cnt,
  output logic [15:0]      stat_miss_cnt
`endif
);

  localparam int          PTR_W   = $clog2(DELAY_MAX);
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [31:0] DLY_LIM = 32'(DELAY_MAX - 1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  d_eff;
  chan_entry_t       dly_ram [DELAY_MAX];
  chan_entry_t       wr_entry;
  chan_entry_t       rd_entry;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_nxt;
  chan_state_t       state;
  chan_state_t       state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic              ber_hit;
  logic              deliver;
  logic [5:0]        lfsr_lo_unused;

  // Clamp the programmed delay into 1..DELAY_MAX-1 so read never equals write
  always_comb begin
    d_eff = PTR_W'(regi_delay_us);
    if (regi_delay_us == 4'd0) begin
      d_eff = PTR_W'(1);
    end else if ({28'd0, regi_delay_us} > DLY_LIM) begin
      d_eff = PTR_W'(DLY_LIM);
    end
  end

  // Pointer difference wraps naturally because DELAY_MAX is a power of two
  assign rd_ptr   = wr_ptr - d_eff;
  assign rd_entry = dly_ram[rd_ptr];
  assign wr_entry = '{vld: tx_en, fk: tx_fk, sym: tx_symbol};

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      wr_ptr <= '0;
      for (int i = 0; i < DELAY_MAX; i++) begin
        dly_ram[i] <= '0;
      end
    end else if (p_1us) begin
      dly_ram[wr_ptr] <= wr_entry;
      wr_ptr          <= wr_ptr + PTR_W'(1);
    end
  end

  bt_chan_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .step   (p_1us),
    .lfsr   (lfsr)
  );

  assign lfsr_lo_unused = lfsr[5:0];

  // Error decision uses the LFSR state present at the read tick, before it steps
  assign ber_hit = (lfsr[LFSR_W-1:6] < regi_ber_thresh);
  // Hop match is checked against the RX channel at read time, not at TX time
  assign deliver = rd_entry.vld & rx_en & (rd_entry.fk == rx_fk);

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      rx_valid  <= 1'b0;
      rx_symbol <= '0;
    end else if (p_1us) begin
      rx_valid  <= deliver;
      rx_symbol <= deliver ? {rd_entry.sym[SYM_W-1:1], rd_entry.sym[0] ^ ber_hit} : '0;
    end
  end

  // Valid entries in flight: +1 per valid write, -1 per valid read
  always_comb begin
    inflight_nxt = inflight;
    if (p_1us) begin
      case ({tx_en, rd_entry.vld && (inflight != '0)})
        2'b10:   inflight_nxt = inflight + CNT_W'(1);
        2'b01:   inflight_nxt = inflight - CNT_W'(1);
        default: inflight_nxt = inflight;
      endcase
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      inflight <= '0;
      state    <= ST_IDLE;
    end else begin
      inflight <= inflight_nxt;
      state    <= state_nxt;
    end
  end

  // Drain ends on the tick whose read retires the last valid entry
  always_comb begin
    state_nxt = state;
    if (p_1us) begin
      case (state)
        ST_IDLE:   if (tx_en) state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (!tx_en) state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (tx_en) begin
            state_nxt = ST_ACTIVE;
          end else if (inflight_nxt == '0) begin
            state_nxt = ST_IDLE;
          end
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  assign chan_busy = (state != ST_IDLE);

`ifdef BT_AIR_CHAN_STATS_EN
  // Clear wins over a same-cycle increment; counters stick at all-ones
  function automatic logic [15:0] stat_upd(input logic [15:0] cnt,
                                           input logic        clr,
                                           input logic        inc);
    logic [15:0] r;
    r = cnt;
    if (clr) begin
      r = '0;
    end else if (inc && (cnt != 16'hFFFF)) begin
      r = cnt + 16'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      stat_sym_cnt  <= '0;
      stat_err_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else begin
      stat_sym_cnt  <= stat_upd(stat_sym_cnt,  regi_stat_clr_p, p_1us & deliver);
      stat_err_cnt  <= stat_upd(stat_err_cnt,  regi_stat_clr_p, p_1us & deliver & ber_hit);
      stat_miss_cnt <= stat_upd(stat_miss_cnt, regi_stat_clr_p, p_1us & rd_entry.vld & ~deliver);
    end
  end
`else
  logic stat_clr_unused;
  assign stat_clr_unused = regi_stat_clr_p;
`endif

endmodule

// File: tb/tb_bt_air_channel.sv
`timescale 1ns/1ps
module tb_bt_air_channel;

  localparam int          DMAX = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_DRAIN = 2;

  logic       clk_6M = 1'b0;
  logic       rstz;
  logic       p_1us;
  logic [2:0] tx_symbol;
  logic [6:0] tx_fk;
  logic       tx_en;
  logic [6:0] rx_fk;
  logic       rx_en;
  logic [3:0] regi_delay_us;
  logic [9:0] regi_ber_thresh;
  logic       regi_stat_clr_p;
  logic [2:0] rx_symbol;
  logic       rx_valid;
  logic       chan_busy;
`ifdef BT_AIR_CHAN_STATS_EN
  logic [15:0] stat_sym_cnt, stat_err_cnt, stat_miss_cnt;
`endif

  always #83 clk_6M = ~clk_6M;

  bt_air_channel #(.DELAY_MAX(DMAX), .LFSR_SEED(SEED)) dut (
    .clk_6M          (clk_6M),
    .rstz            (rstz),
    .p_1us           (p_1us),
    .tx_symbol       (tx_symbol),
    .tx_fk           (tx_fk),
    .tx_en           (tx_en),
    .rx_fk           (rx_fk),
    .rx_en           (rx_en),
    .regi_delay_us   (regi_delay_us),
    .regi_ber_thresh (regi_ber_thresh),
    .regi_stat_clr_p (regi_stat_clr_p),
    .rx_symbol       (rx_symbol),
    .rx_valid        (rx_valid),
    .chan_busy       (chan_busy)
`ifdef BT_AIR_CHAN_STATS_EN
    ,
    .stat_sym_cnt    (stat_sym_cnt),
    .stat_err_cnt    (stat_err_cnt),
    .stat_miss_cnt   (stat_miss_cnt)
`endif
  );

  // Reference model: history of everything sampled since reset, indexed by tick
  typedef struct packed {
    bit       v;
    bit [6:0] fk;
    bit [2:0] sym;
  } ent_t;

  ent_t      hist[$];
  bit [15:0] m_lfsr;
  int        m_inflight;
  int        m_state;
  bit        e_vld;
  bit [2:0]  e_sym;
  int        m_sym_cnt, m_err_cnt, m_miss_cnt;
  bit        stat_clr_req;

  int n_tests = 0;
  int n_fail  = 0;

  int        first, low_at, nvld, flips, side_bad;
  bit [3:0]  seq;
  bit [3:0]  lat_bits;
  logic [2:0] sent[$];
  logic [2:0] exp_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    hist.delete();
    m_lfsr     = SEED;
    m_inflight = 0;
    m_state    = M_IDLE;
    e_vld      = 1'b0;
    e_sym      = 3'd0;
    m_sym_cnt  = 0;
    m_err_cnt  = 0;
    m_miss_cnt = 0;
  endfunction

  function automatic bit [15:0] m_lfsr_step(input bit [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Applies one tick's worth of channel rules to the model using current inputs
  function automatic void model_tick();
    int   d;
    int   n;
    ent_t e;
    bit   flip;
    bit   del;
    d = int'(regi_delay_us);
    if (d < 1) d = 1;
    if (d > DMAX - 1) d = DMAX - 1;
    n = hist.size();
    e = '0;
    if (n - d >= 0) e = hist[n - d];
    flip  = (m_lfsr[15:6] < regi_ber_thresh);
    del   = e.v && rx_en && (e.fk == rx_fk);
    e_vld = del;
    e_sym = del ? {e.sym[2:1], e.sym[0] ^ flip} : 3'd0;
    if (stat_clr_req) begin
      m_sym_cnt = 0; m_err_cnt = 0; m_miss_cnt = 0;
    end else begin
      if (del && m_sym_cnt < 65535) m_sym_cnt++;
      if (del && flip && m_err_cnt < 65535) m_err_cnt++;
      if (e.v && !del && m_miss_cnt < 65535) m_miss_cnt++;
    end
    if (e.v) m_inflight--;
    if (tx_en) m_inflight++;
    if (m_state == M_IDLE) begin
      if (tx_en) m_state = M_ACTIVE;
    end else if (m_state == M_ACTIVE) begin
      if (!tx_en) m_state = M_DRAIN;
    end else begin
      if (tx_en) m_state = M_ACTIVE;
      else if (m_inflight == 0) m_state = M_IDLE;
    end
    hist.push_back('{v: tx_en, fk: tx_fk, sym: tx_symbol});
    m_lfsr = m_lfsr_step(m_lfsr);
  endfunction

  // One 1 us tick: strobe for one clock, compare on the following negedge
  task automatic do_tick();
    @(negedge clk_6M);
    p_1us           = 1'b1;
    regi_stat_clr_p = stat_clr_req;
    model_tick();
    @(negedge clk_6M);
    p_1us           = 1'b0;
    regi_stat_clr_p = 1'b0;
    stat_clr_req    = 1'b0;
    chk("rx_valid",  rx_valid,  e_vld);
    chk("rx_symbol", rx_symbol, e_sym);
    chk("chan_busy", chan_busy, m_state != M_IDLE);
`ifdef BT_AIR_CHAN_STATS_EN
    chk("stat_sym",  stat_sym_cnt,  m_sym_cnt);
    chk("stat_err",  stat_err_cnt,  m_err_cnt);
    chk("stat_miss", stat_miss_cnt, m_miss_cnt);
`endif
    repeat (4) @(negedge clk_6M);
  endtask

  task automatic drain(input int n);
    tx_en = 1'b0;
    repeat (n) do_tick();
  endtask

  function automatic logic [6:0] pick_fk();
    case ($urandom_range(0, 4))
      0:       return 7'd120;
      1, 2:    return 7'd40;
      default: return 7'd41;
    endcase
  endfunction

  initial begin
    rstz = 1'b0; p_1us = 1'b0; tx_symbol = '0; tx_fk = '0; tx_en = 1'b0;
    rx_fk = '0; rx_en = 1'b0; regi_delay_us = '0; regi_ber_thresh = '0;
    regi_stat_clr_p = 1'b0; stat_clr_req = 1'b0;
    lat_bits = 4'b1011;
    repeat (3) @(negedge clk_6M);
    chk("rst_rx_valid",  rx_valid,  1'b0);
    chk("rst_rx_symbol", rx_symbol, 3'd0);
    chk("rst_chan_busy", chan_busy, 1'b0);
    rstz = 1'b1;
    m_reset();
    @(negedge clk_6M);

    // Latency: delay 5, symbols 1,0,1,1
    regi_delay_us = 4'd5; regi_ber_thresh = '0; tx_fk = 7'd23; rx_fk = 7'd23; rx_en = 1'b1;
    first = -1; seq = '0;
    for (int t = 0; t < 12; t++) begin
      tx_en     = (t < 4);
      tx_symbol = (t < 4) ? {2'(t), lat_bits[3 - t]} : 3'd0;
      do_tick();
      if (rx_valid) begin
        if (first < 0) first = t;
        seq = {seq[2:0], rx_symbol[0]};
      end
    end
    chk("lat_first_valid", first, 5);
    chk("lat_bit_seq", seq, 4'b1011);
    drain(16);

    // Frequency gate, then retune RX onto the TX channel mid-burst
    regi_delay_us = 4'd2; tx_fk = 7'd10; rx_fk = 7'd11; first = -1;
    for (int t = 0; t < 12; t++) begin
      if (t == 6) rx_fk = 7'd10;
      tx_en = 1'b1; tx_symbol = 3'($urandom);
      do_tick();
      if (rx_valid && first < 0) first = t;
    end
    chk("fgate_resume_tick", first, 6);
    drain(16);

    // Error injection: near-certain flips, then error-free
    regi_delay_us = 4'd3; regi_ber_thresh = 10'd1023; tx_fk = 7'd55; rx_fk = 7'd55;
    sent.delete(); flips = 0; side_bad = 0;
    for (int t = 0; t < 1200; t++) begin
      if (t == 1000) begin
        chk("ber1023_flips_gt990", flips > 990, 1'b1);
        chk("ber1023_side_bits", side_bad, 0);
        regi_ber_thresh = 10'd0; flips = 0;
      end
      tx_en = 1'b1; tx_symbol = 3'($urandom);
      sent.push_back(tx_symbol);
      do_tick();
      if (rx_valid && t >= 3) begin
        exp_s = sent[t - 3];
        if (rx_symbol[0] != exp_s[0]) flips++;
        if (rx_symbol[2:1] != exp_s[2:1]) side_bad++;
      end
    end
    chk("ber0_flips", flips, 0);
    chk("ber0_side_bits", side_bad, 0);
    drain(16);

    // Burst then drain: busy drops exactly 3 ticks after the last sample
    regi_delay_us = 4'd3; tx_fk = 7'd7; rx_fk = 7'd7;
    for (int t = 0; t < 8; t++) begin
      tx_en = 1'b1; tx_symbol = 3'($urandom);
      do_tick();
      if (t == 0) chk("busy_on_first", chan_busy, 1'b1);
    end
    low_at = -1;
    for (int k = 1; k <= 8; k++) begin
      tx_en = 1'b0;
      do_tick();
      if (!chan_busy && low_at < 0) low_at = k;
    end
    chk("drain_ticks", low_at, 3);
    drain(8);

    // Asynchronous reset while delivering
    regi_delay_us = 4'd4;
    for (int t = 0; t < 8; t++) begin
      tx_en = 1'b1; tx_symbol = 3'b111;
      do_tick();
    end
    chk("pre_rst_valid", rx_valid, 1'b1);
    #40 rstz = 1'b0;
    #1;
    chk("midrst_rx_valid",  rx_valid,  1'b0);
    chk("midrst_rx_symbol", rx_symbol, 3'd0);
    chk("midrst_chan_busy", chan_busy, 1'b0);
    tx_en = 1'b0;
    repeat (2) @(negedge clk_6M);
    rstz = 1'b1;
    m_reset();
    nvld = 0;
    for (int t = 0; t < 20; t++) begin
      do_tick();
      if (rx_valid) nvld++;
    end
    chk("post_rst_stale", nvld, 0);

    // Randomized traffic, delay held constant within each segment
    for (int seg = 0; seg < 3; seg++) begin
      regi_delay_us   = 4'($urandom_range(0, 15));
      regi_ber_thresh = (seg == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
      for (int t = 0; t < 250; t++) begin
        tx_en     = ($urandom_range(0, 3) != 0);
        tx_symbol = 3'($urandom);
        tx_fk     = pick_fk();
        rx_fk     = pick_fk();
        rx_en     = ($urandom_range(0, 7) != 0);
        do_tick();
      end
      drain(16);
    end
    rx_en = 1'b1;

`ifdef BT_AIR_CHAN_STATS_EN
    regi_delay_us = 4'd2; regi_ber_thresh = '0;
    stat_clr_req = 1'b1;
    drain(16);
    tx_fk = 7'd30; rx_fk = 7'd30;
    for (int t = 0; t < 20; t++) begin
      tx_en = 1'b1; tx_symbol = 3'($urandom);
      do_tick();
    end
    tx_fk = 7'd31;
    for (int t = 0; t < 5; t++) do_tick();
    drain(16);
    chk("stats_sym_20",  stat_sym_cnt,  20);
    chk("stats_miss_5",  stat_miss_cnt, 5);
    chk("stats_err_0",   stat_err_cnt,  0);
    tx_fk = 7'd30;
    for (int t = 0; t < 5; t++) begin
      tx_en = 1'b1;
      if (t == 2) stat_clr_req = 1'b1;
      do_tick();
      if (t == 2) chk("stats_clr_coincident", stat_sym_cnt, 0);
    end
    drain(16);
    // Saturation: strobe every cycle so the counter passes 65535 deliveries
    regi_delay_us = 4'd1; tx_en = 1'b1;
    @(negedge clk_6M);
    p_1us = 1'b1;
    repeat (65600) @(negedge clk_6M);
    p_1us = 1'b0;
    @(negedge clk_6M);
    chk("stats_saturate", stat_sym_cnt, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bt_air_channel.md
Name: bt_air_channel

Overview:
- Synthesizable one-direction air-link model between the TX side of one BTradio and the RX side of its peer in the master/slave loopback simulation.
- Forwards TX symbols at 1 Msym/s (one per p_1us) through a programmable propagation delay.
- Gates delivery on TX/RX hop-frequency match and RX enable.
- Injects pseudo-random bit errors at a programmable rate.
- Two instances per link, one per direction.

Parameters:
- DELAY_MAX, 16, depth of the propagation delay line in µs ticks; power of 2; >= 2.
- LFSR_SEED, 16'hACE1, error-LFSR reset value; must be nonzero.

Ports:
- clk_6M  in  1  6 MHz clock.
- rstz  in  1  asynchronous active-low reset.
- p_1us  in  1  1 µs strobe, one clk_6M cycle wide.
- tx_symbol  in  3  transmitted symbol; bit0 = GFSK data bit, bits[2:1] side info.
- tx_fk  in  7  TX hop channel 0..78.
- tx_en  in  1  transmitter active.
- rx_fk  in  7  RX hop channel.
- rx_en  in  1  receiver active.
- regi_delay_us  in  4  propagation delay in µs; effective value = clamp(1..DELAY_MAX-1).
- regi_ber_thresh  in  10  flip bit0 when lfsr[15:6] < thresh; 0 = error-free.
- regi_stat_clr_p  in  1  one-cycle pulse clearing the statistics counters.
- rx_symbol  out  3  delivered symbol; 3'b000 when nothing is delivered.
- rx_valid  out  1  high while rx_symbol carries a delivered symbol.
- chan_busy  out  1  high while any valid entry remains in the delay line.

Behaviour:
- All outputs, the delay line, the FSM and the counters reset asynchronously.
  - Reset values: rx_symbol = 0, rx_valid = 0, chan_busy = 0, lfsr = LFSR_SEED, FSM = IDLE.
- Sampling: on a p_1us cycle, the entry {tx_en, tx_fk, tx_symbol} is written into the circular delay RAM at wr_ptr, and wr_ptr increments mod DELAY_MAX.
- Read pointer: rd_ptr = wr_ptr - d, where d = effective delay, using mod-DELAY_MAX arithmetic.
  - A symbol sampled at tick n is read at tick n+d.
  - rx_symbol/rx_valid update in the cycle after that p_1us tick (registered); they hold between ticks.
- Delivery rule at the read tick: rx_valid = entry.valid AND rx_en AND (entry.fk == rx_fk).
  - The current rx_fk is compared, not the value at TX time.
  - If delivery is false, rx_symbol = 0.
- Error injection:
  - The LFSR (x^16+x^14+x^13+x^11+1, Fibonacci) advances once per p_1us, whether or not a symbol is delivered.
  - Delivered bit0 = entry bit0 XOR (lfsr[15:6] < regi_ber_thresh).
  - Bits [2:1] always pass unchanged.
  - thresh = 1023 gives an error rate of 1023/1024.
- FSM (advances on p_1us ticks only):
  - IDLE -> ACTIVE when tx_en is sampled high.
  - ACTIVE -> DRAIN when tx_en is sampled low.
  - DRAIN -> ACTIVE if tx_en returns high.
  - DRAIN -> IDLE when the count of valid entries in flight reaches 0; this is a 5-bit up/down counter.
  - chan_busy = (state != IDLE).
- regi_delay_us changes take effect at the next tick. Entries skipped or replayed because of the change are tolerated; the in-flight counter stays exact because it counts writes and reads of valid entries.
- Out-of-range fk values (>78) are compared as-is, with no special handling.
- Reset mid-packet: everything clears, and no stale symbols are delivered after rstz rises.

Optional Feature:
- Macro BT_AIR_CHAN_STATS_EN.
- Defined: adds three outputs.
  - stat_sym_cnt[15:0]: delivered symbols.
  - stat_err_cnt[15:0]: flipped bits.
  - stat_miss_cnt[15:0]: valid entries dropped by fk mismatch or rx_en low.
  - All three saturate at 16'hFFFF, clear on regi_stat_clr_p, and reset to 0.
  - If a clear and an increment land in the same cycle, the counter ends at 0.
- Undefined: the outputs and their logic are absent; functional behaviour is otherwise identical.

Decomposition:
- Shared package bt_chan_pkg holds:
  - FSM state enum (IDLE/ACTIVE/DRAIN).
  - LFSR tap constant and width localparams (SYM_W = 3, FK_W = 7).
- One sub-module: bt_chan_lfsr, a 16-bit enable-stepped LFSR with seed parameter.

Test Plan:
- Delay/latency:
  - Stimulus: delay = 5, thresh = 0, tx_fk = rx_fk = 23, rx_en = 1; symbols 1,0,1,1 on consecutive ticks.
  - Response: rx_valid rises 5 ticks + 1 clk after the first sample; rx_symbol bit0 sequence is 1,0,1,1.
- Frequency gate:
  - Stimulus: tx_fk = 10, rx_fk = 11.
  - Response: rx_valid stays 0 and rx_symbol = 0. Switching rx_fk to 10 mid-burst makes delivery resume at the next read tick.
- Error injection:
  - thresh = 1023 over 1000 symbols: > 990 inverted bit0, bits[2:1] unchanged.
  - thresh = 0: zero flips.
- FSM/drain:
  - Stimulus: 8-symbol burst, delay = 3.
  - Response: chan_busy goes high on the first sample and low exactly 3 ticks after the last valid sample; the state sequence IDLE->ACTIVE->DRAIN->IDLE is visible.
- Reset mid-burst:
  - Stimulus: assert rstz = 0 asynchronously between clock edges during delivery.
  - Response: outputs go to 0 immediately; after release, no symbol from the old burst appears.
- Stats (BT_AIR_CHAN_STATS_EN):
  - Stimulus: 20 delivered symbols and 5 mismatched.
  - Response: sym = 20, miss = 5.
  - A clear pulse coincident with a delivery yields 0.
  - Pre-loading near saturation and continuing to deliver holds at FFFF.
